// File: rtl/qdec_bin_dec_engine.sv
// CABAC binary arithmetic decoding engine: regular and bypass bins, context
// update write-back and a 16-bit bit buffer fed from the slice byte stream.
module qdec_bin_dec_engine #(
    parameter int CTX_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_start,
    output logic              init_done,
    input  logic              dec_run,
    input  logic              EPMode,
    input  logic [CTX_AW-1:0] ctx_addr,
    input  logic [6:0]        ctx_rdata,
    output logic              ctx_we,
    output logic [CTX_AW-1:0] ctx_wr_addr,
    output logic [6:0]        ctx_wdata,
    input  logic [7:0]        bs_byte,
    input  logic              bs_vld,
    output logic              bs_rdy,
    output logic              dec_rdy,
    output logic              ruiBin,
    output logic              ruiBin_vld,
    output logic              dec_err
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_INIT       = 3'd1,
        ST_READY      = 3'd2,
        ST_REG_CALC   = 3'd3,
        ST_REG_RENORM = 3'd4
    } state_e;

    // rangeTabLps, rows indexed by pStateIdx, columns by qRangeIdx
    function automatic logic [7:0] range_tab_lps(input logic [5:0] p, input logic [1:0] q);
        logic [31:0] row;
        logic [7:0]  val;
        case (p)
            6'd0:  row = {8'd128, 8'd176, 8'd208, 8'd240};
            6'd1:  row = {8'd128, 8'd167, 8'd197, 8'd227};
            6'd2:  row = {8'd128, 8'd158, 8'd187, 8'd216};
            6'd3:  row = {8'd123, 8'd150, 8'd178, 8'd205};
            6'd4:  row = {8'd116, 8'd142, 8'd169, 8'd195};
            6'd5:  row = {8'd111, 8'd135, 8'd160, 8'd185};
            6'd6:  row = {8'd105, 8'd128, 8'd152, 8'd175};
            6'd7:  row = {8'd100, 8'd122, 8'd144, 8'd166};
            6'd8:  row = {8'd95,  8'd116, 8'd137, 8'd158};
            6'd9:  row = {8'd90,  8'd110, 8'd130, 8'd150};
            6'd10: row = {8'd85,  8'd104, 8'd123, 8'd142};
            6'd11: row = {8'd81,  8'd99,  8'd117, 8'd135};
            6'd12: row = {8'd77,  8'd94,  8'd111, 8'd128};
            6'd13: row = {8'd73,  8'd89,  8'd105, 8'd122};
            6'd14: row = {8'd69,  8'd85,  8'd100, 8'd116};
            6'd15: row = {8'd66,  8'd80,  8'd95,  8'd110};
            6'd16: row = {8'd62,  8'd76,  8'd90,  8'd104};
            6'd17: row = {8'd59,  8'd72,  8'd86,  8'd99};
            6'd18: row = {8'd56,  8'd69,  8'd81,  8'd94};
            6'd19: row = {8'd53,  8'd65,  8'd77,  8'd89};
            6'd20: row = {8'd51,  8'd62,  8'd73,  8'd85};
            6'd21: row = {8'd48,  8'd59,  8'd69,  8'd80};
            6'd22: row = {8'd46,  8'd56,  8'd66,  8'd76};
            6'd23: row = {8'd43,  8'd53,  8'd63,  8'd72};
            6'd24: row = {8'd41,  8'd50,  8'd59,  8'd69};
            6'd25: row = {8'd39,  8'd48,  8'd56,  8'd65};
            6'd26: row = {8'd37,  8'd45,  8'd54,  8'd62};
            6'd27: row = {8'd35,  8'd43,  8'd51,  8'd59};
            6'd28: row = {8'd33,  8'd41,  8'd48,  8'd56};
            6'd29: row = {8'd32,  8'd39,  8'd46,  8'd53};
            6'd30: row = {8'd30,  8'd37,  8'd43,  8'd50};
            6'd31: row = {8'd29,  8'd35,  8'd41,  8'd48};
            6'd32: row = {8'd27,  8'd33,  8'd39,  8'd45};
            6'd33: row = {8'd26,  8'd31,  8'd37,  8'd43};
            6'd34: row = {8'd24,  8'd30,  8'd35,  8'd41};
            6'd35: row = {8'd23,  8'd28,  8'd33,  8'd39};
            6'd36: row = {8'd22,  8'd27,  8'd32,  8'd37};
            6'd37: row = {8'd21,  8'd26,  8'd30,  8'd35};
            6'd38: row = {8'd20,  8'd24,  8'd29,  8'd33};
            6'd39: row = {8'd19,  8'd23,  8'd27,  8'd31};
            6'd40: row = {8'd18,  8'd22,  8'd26,  8'd30};
            6'd41: row = {8'd17,  8'd21,  8'd25,  8'd28};
            6'd42: row = {8'd16,  8'd20,  8'd23,  8'd27};
            6'd43: row = {8'd15,  8'd19,  8'd22,  8'd25};
            6'd44: row = {8'd14,  8'd18,  8'd21,  8'd24};
            6'd45: row = {8'd14,  8'd17,  8'd20,  8'd23};
            6'd46: row = {8'd13,  8'd16,  8'd19,  8'd22};
            6'd47: row = {8'd12,  8'd15,  8'd18,  8'd21};
            6'd48: row = {8'd12,  8'd14,  8'd17,  8'd20};
            6'd49: row = {8'd11,  8'd14,  8'd16,  8'd19};
            6'd50: row = {8'd11,  8'd13,  8'd15,  8'd18};
            6'd51: row = {8'd10,  8'd12,  8'd15,  8'd17};
            6'd52: row = {8'd10,  8'd12,  8'd14,  8'd16};
            6'd53: row = {8'd9,   8'd11,  8'd13,  8'd15};
            6'd54: row = {8'd9,   8'd11,  8'd12,  8'd14};
            6'd55: row = {8'd8,   8'd10,  8'd12,  8'd14};
            6'd56: row = {8'd8,   8'd9,   8'd11,  8'd13};
            6'd57: row = {8'd7,   8'd9,   8'd11,  8'd12};
            6'd58: row = {8'd7,   8'd9,   8'd10,  8'd12};
            6'd59: row = {8'd7,   8'd8,   8'd10,  8'd11};
            6'd60: row = {8'd6,   8'd8,   8'd9,   8'd11};
            6'd61: row = {8'd6,   8'd7,   8'd9,   8'd10};
            6'd62: row = {8'd6,   8'd7,   8'd8,   8'd9};
            default: row = {8'd2, 8'd2,   8'd2,   8'd2};
        endcase
        case (q)
            2'd0:    val = row[31:24];
            2'd1:    val = row[23:16];
            2'd2:    val = row[15:8];
            default: val = row[7:0];
        endcase
        return val;
    endfunction

    function automatic logic [5:0] trans_idx_lps(input logic [5:0] p);
        logic [5:0] t;
        case (p)
            6'd0, 6'd1:          t = 6'd0;
            6'd2:                t = 6'd1;
            6'd3, 6'd4:          t = 6'd2;
            6'd5, 6'd6:          t = 6'd4;
            6'd7:                t = 6'd5;
            6'd8:                t = 6'd6;
            6'd9:                t = 6'd7;
            6'd10:               t = 6'd8;
            6'd11, 6'd12:        t = 6'd9;
            6'd13, 6'd14:        t = 6'd11;
            6'd15:               t = 6'd12;
            6'd16, 6'd17:        t = 6'd13;
            6'd18, 6'd19:        t = 6'd15;
            6'd20, 6'd21:        t = 6'd16;
            6'd22, 6'd23:        t = 6'd18;
            6'd24, 6'd25:        t = 6'd19;
            6'd26, 6'd27:        t = 6'd21;
            6'd28, 6'd29:        t = 6'd22;
            6'd30:               t = 6'd23;
            6'd31, 6'd32:        t = 6'd24;
            6'd33:               t = 6'd25;
            6'd34, 6'd35:        t = 6'd26;
            6'd36, 6'd37:        t = 6'd27;
            6'd38:               t = 6'd28;
            6'd39, 6'd40:        t = 6'd29;
            6'd41, 6'd42, 6'd43: t = 6'd30;
            6'd44:               t = 6'd31;
            6'd45, 6'd46:        t = 6'd32;
            6'd47, 6'd48, 6'd49: t = 6'd33;
            6'd50, 6'd51:        t = 6'd34;
            6'd52, 6'd53, 6'd54: t = 6'd35;
            6'd55, 6'd56, 6'd57: t = 6'd36;
            6'd58, 6'd59, 6'd60: t = 6'd37;
            6'd61, 6'd62:        t = 6'd38;
            default:             t = 6'd63;
        endcase
        return t;
    endfunction

    // Leading zeros of the 9-bit range = renormalisation shift
    function automatic logic [3:0] lzc9(input logic [8:0] r);
        logic [3:0] n;
        casez (r)
            9'b1????????: n = 4'd0;
            9'b01???????: n = 4'd1;
            9'b001??????: n = 4'd2;
            9'b0001?????: n = 4'd3;
            9'b00001????: n = 4'd4;
            9'b000001???: n = 4'd5;
            9'b0000001??: n = 4'd6;
            9'b00000001?: n = 4'd7;
            9'b000000001: n = 4'd8;
            default:      n = 4'd9;
        endcase
        return n;
    endfunction

    state_e              state_q, state_d;
    logic [15:0]         buf_q, buf_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [8:0]          range_q, range_d;
    logic [8:0]          offset_q, offset_d;
    logic [5:0]          pstate_q, pstate_d;
    logic                valmps_q, valmps_d;
    logic [CTX_AW-1:0]   addr_q, addr_d;
    logic [7:0]          rlps_q, rlps_d;
    logic [8:0]          rmps_q, rmps_d;
    logic                lps_q, lps_d;
    logic                init_done_q, init_done_d;
    logic                ruibin_q, ruibin_d;
    logic                ruibin_vld_q, ruibin_vld_d;
    logic                ctx_we_q, ctx_we_d;
    logic [CTX_AW-1:0]   ctx_wr_addr_q, ctx_wr_addr_d;
    logic [6:0]          ctx_wdata_q, ctx_wdata_d;
    logic                dec_err_q, dec_err_d;
    logic                bs_rdy_q, bs_rdy_d;
    logic                dec_rdy_q, dec_rdy_d;

    logic                xfer_s;
    logic                accept_s;
    logic [3:0]          consume_s;
    logic [15:0]         buf_shift_s;
    logic [4:0]          cnt_shift_s;
    logic [7:0]          rlps_s;
    logic [8:0]          rmps_s;
    logic                lps_s;
    logic [9:0]          byp_off_s;
    logic [8:0]          ren_range_s;
    logic [8:0]          ren_offset_s;
    logic [3:0]          ren_n_s;
    logic [8:0]          ren_off_next_s;

    assign xfer_s   = bs_vld && bs_rdy_q;
    assign accept_s = dec_run && dec_rdy_q;

    assign rlps_s = range_tab_lps(pstate_q, range_q[7:6]);
    assign rmps_s = range_q - {1'b0, rlps_s};
    assign lps_s  = (offset_q >= rmps_s);

    assign byp_off_s = {offset_q, buf_q[15]};

    assign ren_range_s    = lps_q ? {1'b0, rlps_q} : rmps_q;
    assign ren_offset_s   = lps_q ? (offset_q - rmps_q) : offset_q;
    assign ren_n_s        = lzc9(ren_range_s);
    assign ren_off_next_s = 9'(({ren_offset_s, buf_q[15:8]} << ren_n_s) >> 8);

    // Next-state logic: FSM, arithmetic, bit buffer and registered outputs
    always_comb begin
        state_d       = state_q;
        range_d       = range_q;
        offset_d      = offset_q;
        pstate_d      = pstate_q;
        valmps_d      = valmps_q;
        addr_d        = addr_q;
        rlps_d        = rlps_q;
        rmps_d        = rmps_q;
        lps_d         = lps_q;
        init_done_d   = 1'b0;
        ruibin_d      = ruibin_q;
        ruibin_vld_d  = 1'b0;
        ctx_we_d      = 1'b0;
        ctx_wr_addr_d = ctx_wr_addr_q;
        ctx_wdata_d   = ctx_wdata_q;
        dec_err_d     = dec_err_q;
        consume_s     = 4'd0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_INIT: begin
                if (cnt_q >= 5'd9) begin
                    range_d     = 9'd510;
                    offset_d    = buf_q[15:7];
                    consume_s   = 4'd9;
                    init_done_d = 1'b1;
                    state_d     = ST_READY;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_READY: begin
                if (accept_s && EPMode) begin
                    consume_s    = 4'd1;
                    ruibin_vld_d = 1'b1;
                    if (byp_off_s >= {1'b0, range_q}) begin
                        ruibin_d = 1'b1;
                        offset_d = 9'(byp_off_s - {1'b0, range_q});
                    end else begin
                        ruibin_d = 1'b0;
                        offset_d = byp_off_s[8:0];
                    end
                end else if (accept_s) begin
                    pstate_d = ctx_rdata[6:1];
                    valmps_d = ctx_rdata[0];
                    addr_d   = ctx_addr;
                    state_d  = ST_REG_CALC;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_REG_CALC: begin
                // Bin and context update are decided here so they can be
                // presented as registered outputs during REG_RENORM.
                rlps_d        = rlps_s;
                rmps_d        = rmps_s;
                lps_d         = lps_s;
                ruibin_vld_d  = 1'b1;
                ctx_we_d      = 1'b1;
                ctx_wr_addr_d = addr_q;
                if (lps_s) begin
                    ruibin_d    = ~valmps_q;
                    ctx_wdata_d = {trans_idx_lps(pstate_q),
                                   (pstate_q == 6'd0) ? ~valmps_q : valmps_q};
                end else begin
                    ruibin_d    = valmps_q;
                    ctx_wdata_d = {(pstate_q >= 6'd62) ? 6'd62 : (pstate_q + 6'd1), valmps_q};
                end
                state_d = ST_REG_RENORM;
            end
            ST_REG_RENORM: begin
                range_d   = ren_range_s << ren_n_s;
                offset_d  = ren_off_next_s;
                consume_s = ren_n_s;
                state_d   = ST_READY;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        buf_shift_s = buf_q << consume_s;
        cnt_shift_s = cnt_q - {1'b0, consume_s};
        if (xfer_s) begin
            buf_d = buf_shift_s | ({bs_byte, 8'h00} >> cnt_shift_s);
            cnt_d = cnt_shift_s + 5'd8;
        end else begin
            buf_d = buf_shift_s;
            cnt_d = cnt_shift_s;
        end

        // Slice start wins over everything: drop the bin in flight and refill
        if (init_start) begin
            state_d      = ST_INIT;
            init_done_d  = 1'b0;
            ruibin_vld_d = 1'b0;
            ctx_we_d     = 1'b0;
            dec_err_d    = 1'b0;
            buf_d        = xfer_s ? {bs_byte, 8'h00} : 16'h0000;
            cnt_d        = xfer_s ? 5'd8 : 5'd0;
        end else if (dec_run && !dec_rdy_q) begin
            dec_err_d = 1'b1;
        end else begin
            dec_err_d = dec_err_q;
        end

        bs_rdy_d  = (state_d != ST_IDLE) && (cnt_d <= 5'd8);
        dec_rdy_d = (state_d == ST_READY) && (cnt_d >= 5'd7);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            buf_q         <= 16'h0000;
            cnt_q         <= 5'd0;
            range_q       <= 9'd0;
            offset_q      <= 9'd0;
            pstate_q      <= 6'd0;
            valmps_q      <= 1'b0;
            addr_q        <= '0;
            rlps_q        <= 8'd0;
            rmps_q        <= 9'd0;
            lps_q         <= 1'b0;
            init_done_q   <= 1'b0;
            ruibin_q      <= 1'b0;
            ruibin_vld_q  <= 1'b0;
            ctx_we_q      <= 1'b0;
            ctx_wr_addr_q <= '0;
            ctx_wdata_q   <= 7'd0;
            dec_err_q     <= 1'b0;
            bs_rdy_q      <= 1'b0;
            dec_rdy_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            cnt_q         <= cnt_d;
            range_q       <= range_d;
            offset_q      <= offset_d;
            pstate_q      <= pstate_d;
            valmps_q      <= valmps_d;
            addr_q        <= addr_d;
            rlps_q        <= rlps_d;
            rmps_q        <= rmps_d;
            lps_q         <= lps_d;
            init_done_q   <= init_done_d;
            ruibin_q      <= ruibin_d;
            ruibin_vld_q  <= ruibin_vld_d;
            ctx_we_q      <= ctx_we_d;
            ctx_wr_addr_q <= ctx_wr_addr_d;
            ctx_wdata_q   <= ctx_wdata_d;
            dec_err_q     <= dec_err_d;
            bs_rdy_q      <= bs_rdy_d;
            dec_rdy_q     <= dec_rdy_d;
        end
    end

    assign init_done   = init_done_q;
    assign ruiBin      = ruibin_q;
    assign ruiBin_vld  = ruibin_vld_q;
    assign ctx_we      = ctx_we_q;
    assign ctx_wr_addr = ctx_wr_addr_q;
    assign ctx_wdata   = ctx_wdata_q;
    assign dec_err     = dec_err_q;
    assign bs_rdy      = bs_rdy_q;
    assign dec_rdy     = dec_rdy_q;

endmodule
